// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Request/response bundle between two requesters and the shared-ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (bit0 = requester 0)
//   req{0,1}_a/_b/_op   : per-requester operands and ALU control code
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_result          : result for the requester flagged in rsp_valid
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Round-robin grant,
// operands/op registered into the ALU for one EXEC cycle, result captured and
// returned to the winner on a valid/ready response channel.
//
// Ports:
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   alu_a_o/_b_o : registered operands to the shared ALU
//   alu_op_o     : registered ALU control code (passed through unmodified)
//   alu_result_i : combinational ALU result
//   busy_o       : high in EXEC or RESP
//   op_count_o   : completed responses, wraps modulo 2^CNTW
//
// state | meaning
// IDLE  | waiting for a request; grant and accept happen in the same cycle
// EXEC  | registered operands drive the ALU; result captured at cycle end
// RESP  | result offered to the winner until it accepts
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNTW  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    alu_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]  alu_a_o,
    output logic [WIDTH-1:0]  alu_b_o,
    output logic [OPW-1:0]    alu_op_o,
    input  logic [WIDTH-1:0]  alu_result_i,
    output logic              busy_o,
    output logic [CNTW-1:0]   op_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             prio_q;
    logic             grant_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] result_q;
    logic [CNTW-1:0]  count_q;

    logic any_valid;
    logic grant_sel;
    logic accept;
    logic rsp_hs;

    assign any_valid = |bus.req_valid;

    // A lone requester wins regardless of priority; the pointer only breaks ties.
    always_comb begin
        grant_sel = bus.req_valid[1];
        if (&bus.req_valid) begin
            grant_sel = prio_q;
        end
    end

    assign accept = (state_q == ST_IDLE) && any_valid;
    // Only the granted requester's ready bit can complete the response.
    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready[grant_q];

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        if (accept) begin
            bus.req_ready = 2'b01 << grant_sel;
        end
        if (state_q == ST_RESP) begin
            bus.rsp_valid = 2'b01 << grant_q;
        end
        busy_o = (state_q == ST_EXEC) || (state_q == ST_RESP);
    end

    // Datapath: operand capture on accept, result capture at end of EXEC,
    // counter and priority update on response handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q   <= 1'b0;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                grant_q <= grant_sel;
                a_q     <= grant_sel ? bus.req1_a  : bus.req0_a;
                b_q     <= grant_sel ? bus.req1_b  : bus.req0_b;
                op_q    <= grant_sel ? bus.req1_op : bus.req0_op;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_result_i;
            end
            if (rsp_hs) begin
                count_q <= count_q + 1'b1;
                prio_q  <= ~grant_q;
            end
        end
    end

    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign alu_op_o       = op_q;
    assign bus.rsp_result = result_q;
    assign op_count_o     = count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed and random transactions against a transaction-level model of the
// arbiter (grant rule, round-robin pointer, expected ALU result, op count).
// A second instance with CNTW=2 mirrors the same stimulus to exercise wrap.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter_if #(.WIDTH(32), .OPW(4)) b1 ();
    alu_share_arbiter_if #(.WIDTH(32), .OPW(4)) b2 ();

    assign b2.req_valid = b1.req_valid;
    assign b2.req0_a    = b1.req0_a;
    assign b2.req0_b    = b1.req0_b;
    assign b2.req0_op   = b1.req0_op;
    assign b2.req1_a    = b1.req1_a;
    assign b2.req1_b    = b1.req1_b;
    assign b2.req1_op   = b1.req1_op;
    assign b2.rsp_ready = b1.rsp_ready;

    logic [31:0] alu_a1, alu_b1, alu_res1, alu_a2, alu_b2, alu_res2;
    logic [3:0]  alu_op1, alu_op2;
    logic        busy1, busy2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res1 = alu_ref(alu_a1, alu_b1, alu_op1);
    assign alu_res2 = alu_ref(alu_a2, alu_b2, alu_op2);

    alu_share_arbiter #(.WIDTH(32), .OPW(4), .CNTW(16)) dut (
        .clk_i(clk), .reset_i(reset), .bus(b1),
        .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_op_o(alu_op1),
        .alu_result_i(alu_res1), .busy_o(busy1), .op_count_o(cnt1)
    );

    alu_share_arbiter #(.WIDTH(32), .OPW(4), .CNTW(2)) dut_wrap (
        .clk_i(clk), .reset_i(reset), .bus(b2),
        .alu_a_o(alu_a2), .alu_b_o(alu_b2), .alu_op_o(alu_op2),
        .alu_result_i(alu_res2), .busy_o(busy2), .op_count_o(cnt2)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    int          exp_count;
    logic        prio_m;
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [3:0]  rop[2];
    int          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_operands();
        b1.req0_a = ra[0]; b1.req0_b = rb[0]; b1.req0_op = rop[0];
        b1.req1_a = ra[1]; b1.req1_b = rb[1]; b1.req1_op = rop[1];
    endtask

    // Called at posedge+1 with the DUT idle. vmask = requests at accept time,
    // extra = additional valid bits raised only while busy, stall = cycles the
    // winner withholds rsp_ready, noise = loser's rsp_ready held high.
    task automatic run_txn(input logic [1:0] vmask, input logic [1:0] extra, input int stall,
                           input bit noise, input bit chk_space);
        int          g;
        logic [1:0]  gm;
        logic [31:0] er;
        g  = (vmask == 2'b11) ? int'(prio_m) : (vmask[1] ? 1 : 0);
        gm = 2'b01 << g;
        er = alu_ref(ra[g], rb[g], rop[g]);
        drive_operands();
        b1.req_valid = vmask;
        b1.rsp_ready = 2'b00;
        #1;
        chk("req_ready_accept", b1.req_ready, gm);
        chk("busy_idle", busy1, 0);
        if (chk_space) chk("accept_spacing", cyc - last_acc, 3);
        last_acc = cyc;
        @(posedge clk); #1;
        b1.req_valid = vmask | extra;
        #1;
        chk("exec_alu_a", alu_a1, ra[g]);
        chk("exec_alu_b", alu_b1, rb[g]);
        chk("exec_alu_op", alu_op1, rop[g]);
        chk("exec_busy", busy1, 1);
        chk("exec_req_ready", b1.req_ready, 2'b00);
        chk("exec_rsp_valid", b1.rsp_valid, 2'b00);
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            b1.rsp_ready = noise ? ~gm : 2'b00;
            #1;
            chk("stall_rsp_valid", b1.rsp_valid, gm);
            chk("stall_rsp_result", b1.rsp_result, er);
            chk("stall_req_ready", b1.req_ready, 2'b00);
            chk("stall_alu_a_hold", alu_a1, ra[g]);
            @(posedge clk); #1;
        end
        b1.rsp_ready = gm | (noise ? ~gm : 2'b00);
        #1;
        chk("rsp_valid", b1.rsp_valid, gm);
        chk("rsp_result", b1.rsp_result, er);
        @(posedge clk); #1;
        exp_count++;
        prio_m = (g == 0);
        b1.req_valid = 2'b00;
        b1.rsp_ready = 2'b00;
        #1;
        chk("done_rsp_valid", b1.rsp_valid, 2'b00);
        chk("done_busy", busy1, 0);
        chk("op_count", cnt1, exp_count % 65536);
        chk("op_count_wrap", cnt2, exp_count % 4);
        chk("idle_alu_op_hold", alu_op1, rop[g]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b1.req_valid = 2'b00;
        b1.rsp_ready = 2'b00;
        @(posedge clk); #1;
        chk("rst_req_ready", b1.req_ready, 2'b00);
        chk("rst_rsp_valid", b1.rsp_valid, 2'b00);
        chk("rst_rsp_result", b1.rsp_result, 0);
        chk("rst_alu_a", alu_a1, 0);
        chk("rst_alu_b", alu_b1, 0);
        chk("rst_alu_op", alu_op1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_op_count", cnt1, 0);
        reset = 1'b0;
        exp_count = 0;
        prio_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        b1.req_valid = 2'b00;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_req_ready", b1.req_ready, 2'b00);
            chk("idle_rsp_valid", b1.rsp_valid, 2'b00);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    logic [3:0] op_tab [6];

    initial begin
        op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        reset = 1'b1;
        b1.req_valid = 2'b00;
        b1.rsp_ready = 2'b00;
        ra = '{32'd0, 32'd0}; rb = '{32'd0, 32'd0}; rop = '{4'd0, 4'd0};
        drive_operands();
        last_acc = 0;
        @(posedge clk); #1;
        do_reset();

        // Single request, SLT: -1 < 1 -> 1
        ra[0] = 32'hFFFF_FFFF; rb[0] = 32'h0000_0001; rop[0] = 4'b0111;
        run_txn(2'b01, 2'b00, 0, 1'b0, 1'b0);

        // Contention and fairness: 0,1,0,1 with 3-cycle accept spacing
        do_reset();
        ra[0] = 32'd5;          rb[0] = 32'd3;          rop[0] = 4'b0110;
        ra[1] = 32'h7FFF_FFFF;  rb[1] = 32'h8000_0000;  rop[1] = 4'b0111;
        run_txn(2'b11, 2'b00, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) run_txn(2'b11, 2'b00, 0, 1'b0, 1'b1);

        // Backpressure: requester 1 add, 5 stall cycles, requester 0 valid while busy,
        // loser's rsp_ready high throughout. Fifth op wraps the CNTW=2 counter to 1.
        ra[1] = 32'd1; rb[1] = 32'd2; rop[1] = 4'b0010;
        run_txn(2'b10, 2'b01, 5, 1'b1, 1'b0);

        // Withdrawn request: requester 0 only pulses while requester 1 is being served
        run_txn(2'b10, 2'b01, 2, 1'b0, 1'b0);
        idle_cycles(3);

        // Reset during EXEC aborts; then priority restarts at 0
        run_txn(2'b01, 2'b00, 0, 1'b0, 1'b0);
        drive_operands();
        b1.req_valid = 2'b10;
        @(posedge clk); #1;
        reset = 1'b1;
        b1.req_valid = 2'b00;
        @(posedge clk); #1;
        chk("abort_rsp_valid", b1.rsp_valid, 2'b00);
        chk("abort_busy", busy1, 0);
        chk("abort_op_count", cnt1, 0);
        chk("abort_rsp_result", b1.rsp_result, 0);
        reset = 1'b0;
        exp_count = 0;
        prio_m = 1'b0;
        b1.rsp_ready = 2'b11;
        @(posedge clk); #1;
        chk("abort_no_response", b1.rsp_valid, 2'b00);
        b1.rsp_ready = 2'b00;
        run_txn(2'b11, 2'b00, 0, 1'b0, 1'b0);

        // Random transactions
        for (int k = 0; k < 40; k++) begin
            logic [1:0] vm;
            for (int r = 0; r < 2; r++) begin
                ra[r]  = $urandom;
                rb[r]  = ($urandom_range(0, 3) == 0) ? ra[r] : $urandom;
                rop[r] = op_tab[$urandom_range(0, 5)];
            end
            vm = 2'($urandom_range(1, 3));
            run_txn(vm, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (add/sub/and/or/slt/nor datapath, 4-bit ALU-control encoding) between two requesters, e.g. the main pipeline and an address/branch-compare unit.
- Arbitrates round-robin and registers operands and operation into the ALU.
- Captures the result and returns it to the winning requester on a valid/ready response channel.
- The block is op-agnostic: alu_op passes through unmodified.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 4, ALU control code width.
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit0 = requester 0.
- req_ready  output  2  per-requester accept strobe; one-hot or zero.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  OPW  requester 0 ALU control code.
- req1_a, req1_b  input  WIDTH  requester 1 operands.
- req1_op  input  OPW  requester 1 ALU control code.
- rsp_valid  output  2  per-requester response valid; one-hot or zero.
- rsp_ready  input  2  per-requester response accept.
- rsp_result  output  WIDTH  result for the requester flagged in rsp_valid.
- alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
- alu_op  output  OPW  control code driven to the shared ALU.
- alu_result  input  WIDTH  combinational ALU result.
- busy  output  1  high in EXEC or RESP.
- op_count  output  CNTW  number of completed responses.

Behaviour:
- Reset (synchronous, active-high, on clk rising edge) clears all outputs and state:
  - state=IDLE, priority pointer=0, req_ready=0, rsp_valid=0, rsp_result=0.
  - alu_a=alu_b=0, alu_op=0, busy=0, op_count=0.
- Reset asserted in any state aborts the in-flight operation; no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise grant one requester. If both are valid, grant the requester pointed to by priority; if only one is valid, grant it regardless of priority.
  - req_ready[grant] is asserted combinationally in this same cycle and is the only cycle it is high. A transfer occurs when req_valid & req_ready.
  - On that edge, latch the granted a/b/op into the operand registers, latch the grant index, and go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op come from the registers and are stable for the whole cycle.
  - At the end of the cycle, capture alu_result into rsp_result and go to RESP.
- RESP:
  - rsp_valid[grant]=1 and rsp_result is held stable until rsp_ready[grant]=1.
  - rsp_ready on the non-granted bit is ignored.
  - On handshake: op_count+1 (wraps modulo 2^CNTW), priority = ~grant, go to IDLE.
  - Backpressure is unbounded; no timeout.
- alu_a/alu_b/alu_op hold their last values in IDLE and RESP; they change only on an accept edge.
- Latency: accept at edge N, result captured at N+1, rsp_valid visible in cycle N+1 → N+2 window. Minimum spacing between accepts is 3 cycles.
- Requests arriving while busy are not accepted (req_ready=0). The requester must hold req_valid and its operands stable until accepted.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- A requester dropping req_valid before acceptance is legal; if the other requester is valid in that cycle, it wins.

Test Plan:
- Single request, SLT: reset, then requester0 sends a=0xFFFFFFFF, b=0x00000001, op=0111 (bench ALU model implements the encoding) → req_ready=01 in accept cycle; alu_a/alu_b/alu_op match after the edge; rsp_valid=01 two cycles after accept; rsp_result=0x00000001; op_count=1.
- Contention, fairness: both valid continuously for 4 ops, requester0 a=5,b=3,op=0110, requester1 a=0x7FFFFFFF,b=0x80000000,op=0111, rsp_ready tied high → grant order 0,1,0,1; results 2, 0, 2, 0; op_count=4; accepts spaced exactly 3 cycles.
- Backpressure: requester1 op=0010 a=1 b=2, rsp_ready[1]=0 for 5 cycles → rsp_valid=10 and rsp_result=3 held for all 5 cycles; rsp_ready[0]=1 during the stall has no effect; req_ready stays 00 while requester0 is valid.
- Reset mid-operation: assert reset during EXEC → next cycle state IDLE, rsp_valid=00, op_count=0; a later request completes normally with priority starting at 0.
- Withdrawn request plus counter wrap: requester0 pulses req_valid only while busy, then drops it → it is never granted and no response is issued. Separately, preload behaviour with CNTW=2 and run 5 ops → op_count sequence 1,2,3,0,1.
